// File: rtl/peripheral_bin2bcd_pkg.sv
// peripheral_bin2bcd_pkg: register offsets, FSM encoding and shared datapath helper
package peripheral_bin2bcd_pkg;
  localparam int DATA_W = 16;
  localparam int DIGITS = 5;
  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W = BCD_W + DATA_W;
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [4:0] OFF_OPERAND = 5'h04;
  localparam logic [4:0] OFF_START = 5'h08;
  localparam logic [4:0] OFF_STATUS = 5'h0C;
  localparam logic [4:0] OFF_RESULT = 5'h10;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    for (int i = 0; i < DIGITS; i++)
      r[4*i+:4] = b[4*i+:4] >= 4'd5 ? b[4*i+:4] + 4'd3 : b[4*i+:4];
    return r;
  endfunction
endpackage

// File: rtl/peripheral_bin2bcd_core.sv
// bin2bcd_core: one-bit-per-clock double-dabble converter with IDLE/SHIFT/DONE FSM
module bin2bcd_core
  import peripheral_bin2bcd_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [DATA_W-1:0] bin,
  output logic              busy,
  output logic              done,
  output logic [BCD_W-1:0]  bcd
);
  state_e           state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d, adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  assign adj = {add3(sr_q[SR_W-1-:BCD_W]), sr_q[DATA_W-1:0]};
  assign busy = busy_q;
  assign done = done_q;
  assign bcd = bcd_q;
  // next-state: load on start, add-3 then shift for DATA_W cycles, publish result
  always_comb begin
    state_d = state_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    busy_d = busy_q;
    done_d = done_q;
    bcd_d = bcd_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = SHIFT;
        sr_d = {{BCD_W{1'b0}}, bin};
        cnt_d = '0;
        done_d = 1'b0;
        busy_d = 1'b1;
      end
      SHIFT: begin
        sr_d = {adj[SR_W-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CNT_W'(DATA_W - 1) ? DONE : SHIFT;
      end
      DONE: begin
        bcd_d = sr_q[SR_W-1-:BCD_W];
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset discards any conversion in flight
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      sr_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bcd_q <= '0;
    end else begin
      state_q <= state_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      bcd_q <= bcd_d;
    end
  end
endmodule

// File: rtl/peripheral_bin2bcd.sv
// peripheral_bin2bcd: bus decode, operand register and registered read mux around bin2bcd_core
module peripheral_bin2bcd
  import peripheral_bin2bcd_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out
);
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [31:0]       d_out_q, d_out_d, rdata;
  logic              wr_en, start, busy, done;
  logic [BCD_W-1:0]  bcd;
  logic              unused_d_in;
  assign unused_d_in = ^d_in[31:DATA_W];
  assign wr_en = cs & wr & ~busy;
  assign start = wr_en & (addr == OFF_START) & d_in[0];
  assign d_out = d_out_q;
  bin2bcd_core u_core (
    .clk   (clk),
    .resetn(resetn),
    .start (start),
    .bin   (operand_q),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );
  // operand latch and read mux; reads see pre-write values, idle cycles return 0
  always_comb begin
    operand_d = wr_en && addr == OFF_OPERAND ? d_in[DATA_W-1:0] : operand_q;
    rdata = addr == OFF_OPERAND ? 32'(operand_q) :
            addr == OFF_STATUS  ? {30'b0, busy, done} :
            addr == OFF_RESULT  ? 32'(bcd) : 32'b0;
    d_out_d = cs & rd ? rdata : 32'b0;
  end
  // bus-side registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      operand_q <= '0;
      d_out_q <= '0;
    end else begin
      operand_q <= operand_d;
      d_out_q <= d_out_d;
    end
  end
endmodule

// File: doc/peripheral_bin2bcd.md
# peripheral_bin2bcd

Memory-mapped binary-to-BCD converter occupying the 0x0044_xxxx window (chip-select slot cs[1]) of the SOC bus. It consumes a 16-bit unsigned binary value written by the FemtoRV32 core and produces a 5-digit packed BCD result using the iterative shift-add-3 (double-dabble) algorithm, one bit per clock. The result is read back through the SOC read mux, typically to drive UART text output or a display.

## Interface
- DATA_W, 16: binary operand width.
- DIGITS, 5: BCD output digits; result width is 4*DIGITS = 20.
- clk  in  1  system clock, 25 MHz in the SOC.
- resetn  in  1  asynchronous, active-low reset.
- d_in  in  32  write data (mem_wdata); only [15:0] and [0] are used, depending on register.
- cs  in  1  chip select from the SOC address decoder.
- addr  in  5  byte offset (mem_addr[4:0]).
- rd  in  1  read strobe (mem_rstrb).
- wr  in  1  write strobe (|mem_wmask).
- d_out  out  32  registered read data.

## Operation
- Register map (byte offsets):
  - 0x04 OPERAND: write, d_in[15:0] latched; read returns the latched operand, zero-extended.
  - 0x08 START: write with d_in[0]=1 begins conversion; d_in[0]=0 is a no-op.
  - 0x0C STATUS: read, bit0 = done, bit1 = busy, upper bits 0.
  - 0x10 RESULT: read, bits[19:0] = packed BCD (digit 0 in [3:0]), upper bits 0.
  - Other offsets: writes ignored, reads return 0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT on START write: shift register <= {20'b0, operand}, bit counter <= 0, done <= 0, busy <= 1.
  - SHIFT: each cycle, every BCD nibble >= 5 gets +3, then the 36-bit register shifts left by 1; counter increments. After the 16th shift -> DONE.
  - DONE: result register <= upper 20 bits, done <= 1, busy <= 0, then -> IDLE.
- done remains 1 until the next START write or reset.
- While busy: OPERAND and START writes are ignored. RESULT keeps its previous value until completion.
- A write and a read in the same cycle cannot occur, because the core issues one access per cycle. If both are asserted, the write takes effect and the read still returns pre-write register values.

## Timing
- Reset values: d_out = 0, result = 0, operand = 0, done = 0, busy = 0, state = IDLE.
- A START write sampled at rising edge N sets busy = 1 at edge N, performs shifts at edges N+1 through N+16, and sets done = 1 at edge N+17.
- Conversion latency is therefore 17 clocks from the START write edge to done visible in STATUS.
- Read path: when cs & rd is sampled at edge N, d_out is updated at edge N with the selected register. The data is valid in the cycle after the strobe, which matches RAM read timing (mem_rbusy = 0).
- When cs & rd is not sampled, d_out is cleared to 0 at the next edge, so the SOC mux never sees stale data.
- If resetn is asserted mid-conversion, the FSM returns to IDLE immediately and all registers are cleared. No partial result is kept.

## Structure
- Shared package / include file contents:
  - Register offsets: OFF_OPERAND, OFF_START, OFF_STATUS, OFF_RESULT.
  - FSM state encoding.
  - DATA_W and DIGITS defaults.
- One sub-module, bin2bcd_core:
  - Ports: clk, resetn, start, bin[15:0], busy, done, bcd[19:0].
  - Contains the FSM, counter and shift/add-3 datapath.
- peripheral_bin2bcd holds only the bus decode, operand register and registered read mux around bin2bcd_core.

## Test plan
- Reset: check that STATUS, RESULT and OPERAND all read 0, and that d_out is 0 while resetn is low.
- Basic conversion: write OPERAND = 0x04D2 (1234), write START = 1, poll STATUS until done. RESULT must be 0x01234, and done must first appear exactly 17 cycles after the START edge.
- Boundaries:
  - Operand 0x0000 gives RESULT 0x00000.
  - Operand 0xFFFF gives RESULT 0x65535.
  - Operand 9 gives 0x00009; operand 10 gives 0x00010.
- Busy protection: during a conversion of 0x0063 (99), write OPERAND = 0x1234 and START again. RESULT must be 0x00099, OPERAND must still read 0x0063, and only one done event may occur.
- Reset mid-operation: assert resetn low 8 cycles after START. After release, STATUS and RESULT must read 0, and a fresh conversion of 500 must give 0x00500.
- Decode: with cs = 0, write START = 1 at offset 0x08, then read with cs = 0. No conversion may start and d_out must stay 0. A read of offset 0x14 must return 0.
